// File: rtl/tt_uart_tx.sv
// tt_uart_tx: 8N1 UART transmitter fed by a small byte FIFO.
// Define TT_UART_TX_PARITY_EN to insert a parity bit after the data bits.
module tt_uart_tx #(
   parameter int CLKS_PER_BIT = 434,
   parameter int FIFO_DEPTH   = 4
) (
   input  logic                        clk_i,
   input  logic                        rst_ni,
   input  logic [7:0]                  data_i,
   input  logic                        valid_i,
   output logic                        ready_o,
   input  logic                        parity_odd_i,
   output logic                        tx_o,
   output logic                        busy_o,
   output logic [$clog2(FIFO_DEPTH):0] fifo_count_o
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int CW = $clog2(CLKS_PER_BIT);
   localparam logic [CW-1:0] BIT_LAST = CW'(CLKS_PER_BIT - 1);
   localparam logic [AW:0]   FULL     = (AW+1)'(FIFO_DEPTH);

`ifdef TT_UART_TX_PARITY_EN
   typedef enum logic [2:0] {
      S_IDLE, S_START, S_DATA, S_PARITY, S_STOP
   } state_t;
`else
   typedef enum logic [1:0] {
      S_IDLE, S_START, S_DATA, S_STOP
   } state_t;
`endif

   state_t         state_q, state_d;
   logic [CW-1:0]  cnt_q;
   logic [2:0]     bit_q;
   logic [7:0]     shift_q;
   logic [7:0]     mem [FIFO_DEPTH];
   logic [AW-1:0]  wr_q, rd_q;
   logic [AW:0]    count_q;
   logic           tx_d;
   logic           pop;
   logic           push;
   logic           nempty;
   logic           bit_end;
   logic           last_data;

   assign ready_o      = (count_q != FULL);
   assign fifo_count_o = count_q;
   assign busy_o       = (state_q != S_IDLE);
   assign push         = valid_i && ready_o;
   assign nempty       = (count_q != '0);
   assign bit_end      = (cnt_q == BIT_LAST);
   assign last_data    = (bit_q == 3'd7);

`ifdef TT_UART_TX_PARITY_EN
   logic par_q;

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         par_q <= 1'b0;
      end else if (pop) begin
         par_q <= ^mem[rd_q] ^ parity_odd_i;
      end
   end
`else
   logic unused_parity;
   assign unused_parity = parity_odd_i;
`endif

   // state register
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // next-state logic
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         S_IDLE: begin
            if (nempty) state_d = S_START;
         end
         S_START: begin
            if (bit_end) state_d = S_DATA;
         end
         S_DATA: begin
`ifdef TT_UART_TX_PARITY_EN
            if (bit_end && last_data) state_d = S_PARITY;
         end
         S_PARITY: begin
            if (bit_end) state_d = S_STOP;
`else
            if (bit_end && last_data) state_d = S_STOP;
`endif
         end
         S_STOP: begin
            if (bit_end) state_d = nempty ? S_START : S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // output logic: next line level and FIFO pop
   always_comb begin
      tx_d = tx_o;
      pop  = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            pop  = nempty;
            tx_d = !nempty;
         end
         S_START: begin
            if (bit_end) tx_d = shift_q[0];
         end
         S_DATA: begin
            if (bit_end) begin
`ifdef TT_UART_TX_PARITY_EN
               tx_d = last_data ? par_q : shift_q[1];
`else
               tx_d = last_data ? 1'b1 : shift_q[1];
`endif
            end
         end
`ifdef TT_UART_TX_PARITY_EN
         S_PARITY: begin
            if (bit_end) tx_d = 1'b1;
         end
`endif
         S_STOP: begin
            if (bit_end) begin
               pop  = nempty;
               tx_d = !nempty;
            end
         end
         default: tx_d = 1'b1;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         tx_o    <= 1'b1;
         cnt_q   <= '0;
         bit_q   <= '0;
         shift_q <= '0;
      end else begin
         tx_o <= tx_d;
         if (state_q == S_IDLE || bit_end) begin
            cnt_q <= '0;
         end else begin
            cnt_q <= cnt_q + CW'(1);
         end
         if (pop) begin
            bit_q   <= '0;
            shift_q <= mem[rd_q];
         end else if (state_q == S_DATA && bit_end) begin
            bit_q   <= bit_q + 3'd1;
            shift_q <= {1'b0, shift_q[7:1]};
         end
      end
   end

   // pointers wrap naturally since the depth is a power of two
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         wr_q    <= '0;
         rd_q    <= '0;
         count_q <= '0;
      end else begin
         if (push) wr_q <= wr_q + AW'(1);
         if (pop)  rd_q <= rd_q + AW'(1);
         if (push && !pop) begin
            count_q <= count_q + (AW+1)'(1);
         end else if (pop && !push) begin
            count_q <= count_q - (AW+1)'(1);
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (push) mem[wr_q] <= data_i;
   end

endmodule

// File: tb/tb_tt_uart_tx.sv
// tb_tt_uart_tx: frame-level model of the UART transmitter plus
// directed vectors with hand-computed line levels.
module tb_tt_uart_tx;

   localparam int CPB   = 4;
   localparam int DEPTH = 4;
`ifdef TT_UART_TX_PARITY_EN
   localparam int F = 11;
`else
   localparam int F = 10;
`endif
   localparam int FC = F * CPB;

   logic       clk;
   logic       rst_ni;
   logic [7:0] data_i;
   logic       valid_i;
   logic       ready_o;
   logic       parity_odd_i;
   logic       tx_o;
   logic       busy_o;
   logic [2:0] fifo_count_o;

   tt_uart_tx #(
      .CLKS_PER_BIT(CPB),
      .FIFO_DEPTH  (DEPTH)
   ) dut (
      .clk_i       (clk),
      .rst_ni      (rst_ni),
      .data_i      (data_i),
      .valid_i     (valid_i),
      .ready_o     (ready_o),
      .parity_odd_i(parity_odd_i),
      .tx_o        (tx_o),
      .busy_o      (busy_o),
      .fifo_count_o(fifo_count_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_vec = 0;
   int n_err = 0;
   bit chk_en = 0;

   task automatic chk(input string nm, input int act_v, input int exp_v);
      n_vec++;
      if (act_v != exp_v) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d at %0t",
                  nm, act_v, exp_v, $time);
      end
   endtask

   // Model: queue of bytes, a frame bit array, and a cycle offset into it
   byte unsigned mq[$];
   bit           fb [11];
   bit           act = 0;
   int           t = 0;

   always @(posedge clk) begin
      bit acc;
      byte unsigned b;
      if (!rst_ni) begin
         mq.delete();
         act = 0;
         t = 0;
      end else begin
         acc = valid_i && (mq.size() != DEPTH);
         if (act) begin
            t++;
            if (t == FC) act = 0;
         end
         if (!act && mq.size() > 0) begin
            b = mq.pop_front();
            fb[0] = 1'b0;
            for (int k = 0; k < 8; k++) fb[k+1] = b[k];
            fb[9] = ^b ^ parity_odd_i;
            fb[F-1] = 1'b1;
            act = 1;
            t = 0;
         end
         if (acc) mq.push_back(data_i);
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         chk("m_tx", int'(tx_o), act ? int'(fb[t / CPB]) : 1);
         chk("m_busy", int'(busy_o), int'(act));
         chk("m_count", int'(fifo_count_o), mq.size());
         chk("m_ready", int'(ready_o), int'(mq.size() != DEPTH));
      end
   end

   task automatic wait_n(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic push_one(input logic [7:0] b);
      data_i  = b;
      valid_i = 1'b1;
      @(negedge clk);
      valid_i = 1'b0;
   endtask

   task automatic wait_idle(input int lim);
      int g = 0;
      while (busy_o && g < lim) begin
         @(negedge clk);
         g++;
      end
      chk("idle_timeout", int'(busy_o), 0);
   endtask

   logic [7:0]  b2b [5];
   logic [10:0] pat;
   int          busy_cnt;
   int          i;
   int          guard;
   logic        rdy;

   initial begin
      rst_ni       = 1'b0;
      valid_i      = 1'b0;
      data_i       = 8'h00;
      parity_odd_i = 1'b0;
      @(negedge clk);
      chk_en = 1;
      @(negedge clk);
      chk("rst_tx", int'(tx_o), 1);
      chk("rst_busy", int'(busy_o), 0);
      chk("rst_ready", int'(ready_o), 1);
      chk("rst_count", int'(fifo_count_o), 0);
      rst_ni = 1'b1;
      wait_n(3);

      // single byte 0xA5
`ifdef TT_UART_TX_PARITY_EN
      pat = 11'b10101001010;
`else
      pat = 11'b01101001010;
`endif
      push_one(8'hA5);
      chk("a5_idle", int'(tx_o), 1);
      @(negedge clk);
      chk("a5_fall", int'(tx_o), 0);
      wait_n(CPB / 2);
      for (int s = 0; s < F; s++) begin
         chk("a5_bit", int'(tx_o), int'(pat[s]));
         if (s < F - 1) wait_n(CPB);
      end
      wait_n(1);
      chk("a5_busy_last", int'(busy_o), 1);
      wait_n(1);
      chk("a5_busy_end", int'(busy_o), 0);
      wait_n(3);

      // back-to-back until full
      b2b[0] = 8'h00; b2b[1] = 8'hFF; b2b[2] = 8'h55;
      b2b[3] = 8'h0F; b2b[4] = 8'hAA;
      busy_cnt = 0;
      i = 0;
      guard = 0;
      while (i < 5 && guard < 200) begin
         data_i  = b2b[i];
         valid_i = 1'b1;
         rdy     = ready_o;
         if (busy_o) busy_cnt++;
         @(negedge clk);
         guard++;
         if (rdy) i++;
      end
      valid_i = 1'b0;
      chk("full_ready", int'(ready_o), 0);
      chk("full_count", int'(fifo_count_o), 4);
      guard = 0;
      while (busy_o && guard < 2000) begin
         busy_cnt++;
         @(negedge clk);
         guard++;
      end
      chk("b2b_busy_cycles", busy_cnt, 5 * FC);
      wait_n(3);

      // push on the same edge as the stop-end pop
      push_one(8'h3C);
      wait_n(3);
      push_one(8'hC3);
      wait_n(FC - 4);
      chk("pp_count_before", int'(fifo_count_o), 1);
      data_i  = 8'h5A;
      valid_i = 1'b1;
      @(negedge clk);
      valid_i = 1'b0;
      chk("pp_count_after", int'(fifo_count_o), 1);
      chk("pp_start", int'(tx_o), 0);
      wait_idle(4 * FC);
      wait_n(3);

      // reset during data bit 3 with two bytes queued
      push_one(8'h08);
      push_one(8'h11);
      push_one(8'h22);
      chk("mr_count", int'(fifo_count_o), 2);
      wait_n(16);
      chk("mr_busy", int'(busy_o), 1);
      chk("mr_bit3", int'(tx_o), 1);
      rst_ni = 1'b0;
      @(negedge clk);
      rst_ni = 1'b1;
      chk("mr_tx", int'(tx_o), 1);
      chk("mr_cnt", int'(fifo_count_o), 0);
      chk("mr_idle", int'(busy_o), 0);
      wait_n(100);
      chk("mr_quiet_tx", int'(tx_o), 1);
      chk("mr_quiet_busy", int'(busy_o), 0);

`ifdef TT_UART_TX_PARITY_EN
      parity_odd_i = 1'b0;
      push_one(8'h07);
      wait_n(39);
      chk("par_even", int'(tx_o), 1);
      wait_idle(2 * FC);
      wait_n(2);
      parity_odd_i = 1'b1;
      push_one(8'h07);
      wait_n(39);
      chk("par_odd", int'(tx_o), 0);
      wait_idle(2 * FC);
`endif

      wait_n(2);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/tt_uart_tx.md
Name: tt_uart_tx

Overview:
- Byte-serial UART transmitter for the tt_um_anujic top.
- Drives the serial line out on uo_out[0]; it is the transmit end of the same 8N1 link whose receiver samples ui_in.
- Accepts bytes through a valid/ready port into a small FIFO.
- Serialises frames back-to-back at a fixed bit period derived from the system clock.

Parameters:
- CLKS_PER_BIT, 434, clock cycles per serial bit (50 MHz / 115200); legal range >= 2.
- FIFO_DEPTH, 4, byte FIFO entries; power of two, >= 2.

Ports:
- clk_i  input  1  system clock; all logic rising-edge.
- rst_ni  input  1  synchronous active-low reset.
- data_i  input  8  byte to transmit.
- valid_i  input  1  data_i valid.
- ready_o  output  1  FIFO can accept; push occurs when valid_i && ready_o at the rising edge.
- parity_odd_i  input  1  parity select (1 = odd); used only with the optional feature, otherwise ignored.
- tx_o  output  1  serial line, idle high.
- busy_o  output  1  FSM not in IDLE.
- fifo_count_o  output  $clog2(FIFO_DEPTH)+1  bytes currently queued.

Behaviour:
- Reset and interface:
  - One clock; reset is synchronous, active-low, sampled on the rising edge of clk_i.
  - Reset values: tx_o=1, busy_o=0, fifo_count_o=0, ready_o=1. FIFO pointers, baud counter and bit index are cleared.
  - ready_o is combinational: (fifo_count_o != FIFO_DEPTH). It depends on the current count only, so a same-cycle pop does not admit a push into a full FIFO.
  - Push when full: not possible (ready_o=0). data_i is held off and never dropped silently.
- FSM states: IDLE, START, DATA, [PARITY], STOP.
  - IDLE: tx_o=1. If count>0 at an edge: pop head into shift register, baud counter=0, bit index=0, go to START.
  - Result of the above: tx_o falls on the edge after the push edge when the FIFO was empty.
  - START: tx_o=0 for CLKS_PER_BIT cycles, then DATA.
  - DATA: tx_o=shift[0], LSB first, each bit held CLKS_PER_BIT cycles. After bit 7 go to PARITY if compiled in, else STOP.
  - STOP: tx_o=1 for CLKS_PER_BIT cycles. At the end, if count>0 pop and go directly to START (zero idle gap); else go to IDLE.
- Timing and arithmetic:
  - Baud counter counts 0..CLKS_PER_BIT-1, width $clog2(CLKS_PER_BIT). A bit ends on the cycle the counter equals CLKS_PER_BIT-1; the counter then wraps to 0.
  - Frame length: exactly 10*CLKS_PER_BIT cycles (11*CLKS_PER_BIT with parity).
  - tx_o is registered and glitch-free; it changes only at bit boundaries.
- FIFO:
  - Circular buffer; read/write pointers wrap modulo FIFO_DEPTH.
  - Simultaneous push and pop: count unchanged, and the popped entry is the old head.
  - A push into an empty FIFO is not poppable until the following edge.
- Boundary cases:
  - Reset mid-frame: on the reset edge tx_o=1, FSM=IDLE, FIFO flushed. The partial frame is abandoned and not resumed.
  - data_i and valid_i are don't-care while ready_o=0.

Optional Feature:
- Macro: TT_UART_TX_PARITY_EN.
- Defined:
  - PARITY state is inserted after DATA; tx_o = ^byte ^ parity_odd_i for CLKS_PER_BIT cycles.
  - parity_odd_i is sampled at pop time and held per frame.
  - Frame is 11*CLKS_PER_BIT cycles.
- Undefined:
  - No PARITY state and no parity logic; parity_odd_i is unused.
  - Frame is 10*CLKS_PER_BIT cycles.

Test Plan:
- Reset: CLKS_PER_BIT=4, rst_ni=0 for 2 cycles -> tx_o=1, busy_o=0, ready_o=1, fifo_count_o=0.
- Single byte: push 0xA5 -> tx_o falls 1 cycle later. Line reads 0,1,0,1,0,0,1,0,1,1, each level exactly 4 cycles. Then busy_o=0.
- Back-to-back and full: push 0x00,0xFF,0x55,0x0F,0xAA with valid_i held continuously:
  - ready_o drops while 4 are queued.
  - Frames are contiguous with no idle gap between stop and the next start bit.
  - All 5 bytes arrive in order.
- Simultaneous push/pop: push arriving on the same edge as the STOP-end pop -> fifo_count_o unchanged, ordering preserved.
- Reset mid-frame: assert rst_ni=0 during DATA bit 3 with 2 bytes queued -> next edge tx_o=1, count=0. No further frames without new pushes.
- Parity (TT_UART_TX_PARITY_EN defined):
  - Push 0x07 with parity_odd_i=0 -> parity bit 1.
  - parity_odd_i=1 -> parity bit 0.
  - Frame length 44 cycles.
